ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, maximum WAIT-state cycles before a transaction is aborted; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cli_req  input  2  per-client request; bit i belongs to client i.
REQ-005 cli_rdwr  input  2  per-client direction; 1 = write, 0 = read.
REQ-006 cli_addr  input  56  packed client addresses; bits [28i+27:28i] belong to client i.
REQ-007 cli_wdata  input  64  packed client write data; bits [32i+31:32i] belong to client i.
REQ-008 cli_done  output  2  one-cycle completion pulse to the granted client.
REQ-009 cli_err  output  2  timeout flag; valid only in the cycle its cli_done bit is high.
REQ-010 cli_rdata  output  32  read data; valid with cli_done for a read.
REQ-011 cli_gnt  output  2  one-hot grant; high from ISSUE through DONE inclusive.
REQ-012 ctl_go  output  1  one-cycle transaction start to the master RAM controller.
REQ-013 ctl_rdwr  output  1  latched direction; 1 = write.
REQ-014 ctl_address  output  28  latched address.
REQ-015 ctl_wdata  output  32  latched write data.
REQ-016 ctl_read_valid  input  1  read data is present on ctl_read_data.
REQ-017 ctl_read_data  input  32  read data from the controller.
REQ-018 ctl_write_done  input  1  write has completed.
REQ-019 spurious_err  output  1  sticky flag for completion inputs seen outside WAIT.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and DONE.
REQ-021 In IDLE with any cli_req bit high, the block SHALL select one client, latch that client's rdwr, address and wdata into the ctl_* registers, and move to ISSUE.
REQ-022 The selection SHALL be round-robin: the client granted last has the lower priority, and client 0 wins after reset.
REQ-023 In ISSUE, ctl_go SHALL be high for exactly one cycle, the timeout counter SHALL clear to 0, and the FSM SHALL move to WAIT.
REQ-024 In WAIT, a read SHALL complete on ctl_read_valid, capturing ctl_read_data; a write SHALL complete on ctl_write_done; the FSM SHALL then move to DONE with error = 0.
REQ-025 In WAIT, the timeout counter SHALL increment every cycle.
REQ-026 If the counter equals TIMEOUT_CYCLES-1 with no completion in that same cycle, the FSM SHALL move to DONE with error = 1; on a tie, completion takes precedence.
REQ-027 In DONE, the block SHALL pulse cli_done and cli_err for the granted client, drive cli_rdata, update the round-robin pointer, and return to IDLE.
REQ-028 Minimum latency SHALL be 3 cycles: req sampled in IDLE, ctl_go the next cycle, completion the cycle after that, and cli_done the cycle after completion.
REQ-029 Clients SHALL hold req and all fields stable until cli_done.
REQ-030 A req still high in IDLE after DONE SHALL be re-arbitrated as a new request.
REQ-031 Completion inputs asserted in IDLE, ISSUE or DONE SHALL be ignored for data and SHALL set spurious_err until reset.
REQ-032 cli_rdata SHALL hold its last value between transactions; it SHALL read 0 after a write.

Reset
REQ-033 On reset going low, all outputs, the ctl_* registers, the counter and spurious_err SHALL clear to 0 asynchronously; the FSM SHALL enter IDLE and the pointer SHALL favour client 0.
REQ-034 A reset during ISSUE, WAIT or DONE SHALL abort the transaction with no cli_done pulse.

Structure
REQ-035 Package mm_pkg SHALL hold the state enum, ADDR_W = 28, DATA_W = 32 and NUM_CLIENTS = 2.
REQ-036 The timeout counter SHALL be one sub-module, mm_timeout, with clear, enable and expired ports.

Verification
REQ-037 Single read: client 0 reads 0x8000008 and the controller returns 0xAAAA0000 one cycle after ctl_go -> cli_done = 01 and cli_rdata = 0xAAAA0000 three cycles after req.
REQ-038 Simultaneous: both clients request from reset -> client 0 is served first, then client 1, with cli_gnt one-hot throughout.
REQ-039 Fairness: both clients keep requesting for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-040 Timeout: client 1 writes 0x8000004 and no ctl_write_done arrives, TIMEOUT_CYCLES = 8 -> cli_done = 10 and cli_err = 10 exactly 8 WAIT cycles after ISSUE.
REQ-041 Tie and robustness: completion in the final timeout cycle -> err = 0.
REQ-042 Spurious completion in IDLE -> spurious_err = 1 until reset.
REQ-043 Reset asserted during WAIT -> no cli_done pulse and all outputs read 0.

Source files
------------

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Brief    : Shared types, widths and arbitration helpers for ram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mm_pkg;

  localparam int ADDR_W      = 28;
  localparam int DATA_W      = 32;
  localparam int NUM_CLIENTS = 2;
  localparam int CLI_IDX_W   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [CLI_IDX_W-1:0]   cli_idx_t;
  typedef logic [NUM_CLIENTS-1:0] cli_vec_t;

  function automatic cli_vec_t cli_onehot(input cli_idx_t idx);
    cli_vec_t oh;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      oh[i] = (idx == cli_idx_t'(i));
    end
    return oh;
  endfunction

  // First requester found scanning upward from prio, wrapping around.
  function automatic cli_idx_t rr_pick(input cli_vec_t req, input cli_idx_t prio);
    cli_idx_t pick;
    cli_idx_t idx;
    logic     found;
    pick  = prio;
    found = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = cli_idx_t'((int'(prio) + i) % NUM_CLIENTS);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic cli_idx_t rr_next(input cli_idx_t cur);
    return (int'(cur) == NUM_CLIENTS - 1) ? '0 : cur + 1'b1;
  endfunction

endpackage : mm_pkg
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_if
// Brief    : Client-side and controller-side signals of the RAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if;
  import mm_pkg::*;

  logic [NUM_CLIENTS-1:0]        cli_req;
  logic [NUM_CLIENTS-1:0]        cli_rdwr;
  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr;
  logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata;
  logic [NUM_CLIENTS-1:0]        cli_done;
  logic [NUM_CLIENTS-1:0]        cli_err;
  logic [DATA_W-1:0]             cli_rdata;
  logic [NUM_CLIENTS-1:0]        cli_gnt;

  logic                          ctl_go;
  logic                          ctl_rdwr;
  logic [ADDR_W-1:0]             ctl_address;
  logic [DATA_W-1:0]             ctl_wdata;
  logic                          ctl_read_valid;
  logic [DATA_W-1:0]             ctl_read_data;
  logic                          ctl_write_done;

  // The arbiter itself
  modport slave (
    input  cli_req, cli_rdwr, cli_addr, cli_wdata,
    input  ctl_read_valid, ctl_read_data, ctl_write_done,
    output cli_done, cli_err, cli_rdata, cli_gnt,
    output ctl_go, ctl_rdwr, ctl_address, ctl_wdata
  );

  // Clients plus RAM controller, as seen from outside the arbiter
  modport master (
    output cli_req, cli_rdwr, cli_addr, cli_wdata,
    output ctl_read_valid, ctl_read_data, ctl_write_done,
    input  cli_done, cli_err, cli_rdata, cli_gnt,
    input  ctl_go, ctl_rdwr, ctl_address, ctl_wdata
  );

endinterface : ram_port_arbiter_if
`default_nettype wire

// File: rtl/mm_timeout.sv
`default_nettype none
// ============================================================================
// Module   : mm_timeout
// Brief    : WAIT-state cycle counter; expired marks the last allowed cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mm_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                 c_CNT_W = 16;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == c_LAST);

endmodule : mm_timeout
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Round-robin arbiter sharing one RAM controller between clients.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import mm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  ram_port_arbiter_if.slave bus,
  output logic              spurious_err
);

  state_e            r_state;
  cli_idx_t          r_sel;
  cli_idx_t          r_prio;
  cli_idx_t          w_pick;
  logic              w_complete;
  logic              w_expired;
  logic              w_any_cpl;
  logic              w_cnt_clear;
  logic              w_cnt_enable;
  logic [ADDR_W-1:0] w_addr  [NUM_CLIENTS];
  logic [DATA_W-1:0] w_wdata [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign w_addr[g]  = bus.cli_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata[g] = bus.cli_wdata[g*DATA_W +: DATA_W];
  end

  assign w_pick       = rr_pick(bus.cli_req, r_prio);
  assign w_any_cpl    = bus.ctl_read_valid | bus.ctl_write_done;
  assign w_complete   = (r_state == ST_WAIT) &&
                        (bus.ctl_rdwr ? bus.ctl_write_done : bus.ctl_read_valid);
  assign w_cnt_clear  = (r_state == ST_ISSUE);
  assign w_cnt_enable = (r_state == ST_WAIT);

  mm_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_cnt_clear),
    .enable  (w_cnt_enable),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_sel           <= '0;
      r_prio          <= '0;
      spurious_err    <= 1'b0;
      bus.cli_done    <= '0;
      bus.cli_err     <= '0;
      bus.cli_rdata   <= '0;
      bus.cli_gnt     <= '0;
      bus.ctl_go      <= 1'b0;
      bus.ctl_rdwr    <= 1'b0;
      bus.ctl_address <= '0;
      bus.ctl_wdata   <= '0;
    end else begin
      bus.ctl_go   <= 1'b0;
      bus.cli_done <= '0;
      bus.cli_err  <= '0;

      // Completions only mean something while a transaction is waiting.
      if (w_any_cpl && (r_state != ST_WAIT)) begin
        spurious_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (|bus.cli_req) begin
            r_sel           <= w_pick;
            bus.cli_gnt     <= cli_onehot(w_pick);
            bus.ctl_rdwr    <= bus.cli_rdwr[w_pick];
            bus.ctl_address <= w_addr[w_pick];
            bus.ctl_wdata   <= w_wdata[w_pick];
            bus.ctl_go      <= 1'b1;
            r_state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion arriving in the expiry cycle still counts as success.
          if (w_complete || w_expired) begin
            bus.cli_done <= cli_onehot(r_sel);
            bus.cli_err  <= w_complete ? '0 : cli_onehot(r_sel);
            if (bus.ctl_rdwr) begin
              bus.cli_rdata <= '0;
            end else if (w_complete) begin
              bus.cli_rdata <= bus.ctl_read_data;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus.cli_gnt <= '0;
          r_prio      <= rr_next(r_sel);
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : ram_port_arbiter
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Self-checking bench: timestamp-based transaction model plus
//            directed literal checks and a randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;
  import mm_pkg::*;

  localparam int c_T = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic spurious_err;

  ram_port_arbiter_if bus();

  ram_port_arbiter #(
    .TIMEOUT_CYCLES (c_T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .spurious_err (spurious_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a transaction is described by the edge it was granted on and the
  // edge its completion (or timeout) was accepted on.
  longint            edge_n = 0;
  bit                m_busy;
  bit                m_cli;
  bit                m_wr;
  bit                m_err;
  bit                m_spur;
  bit                m_prio;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  longint            t_grant;
  longint            t_cpl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic m_reset();
    m_busy  = 1'b0;
    m_cli   = 1'b0;
    m_wr    = 1'b0;
    m_err   = 1'b0;
    m_spur  = 1'b0;
    m_prio  = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
    t_grant = -100;
    t_cpl   = -1;
  endtask

  task automatic m_step();
    bit cpl_in;
    bit hit;
    edge_n++;
    cpl_in = bus.ctl_read_valid | bus.ctl_write_done;
    if (!m_busy) begin
      if (cpl_in) m_spur = 1'b1;
      if (bus.cli_req != 2'b00) begin
        m_cli   = bus.cli_req[m_prio] ? m_prio : ~m_prio;
        m_wr    = bus.cli_rdwr[m_cli];
        m_addr  = m_cli ? bus.cli_addr[55:28]  : bus.cli_addr[27:0];
        m_wdata = m_cli ? bus.cli_wdata[63:32] : bus.cli_wdata[31:0];
        t_grant = edge_n;
        t_cpl   = -1;
        m_busy  = 1'b1;
      end
    end else if (t_cpl >= 0) begin
      if (cpl_in) m_spur = 1'b1;
      m_busy = 1'b0;
      m_prio = ~m_cli;
    end else if (edge_n == t_grant + 1) begin
      if (cpl_in) m_spur = 1'b1;
    end else begin
      hit = m_wr ? bus.ctl_write_done : bus.ctl_read_valid;
      if (hit || (edge_n == t_grant + 1 + c_T)) begin
        t_cpl = edge_n;
        m_err = !hit;
        if (m_wr) m_rdata = '0;
        else if (hit) m_rdata = bus.ctl_read_data;
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0] oh;
    logic [1:0] e_gnt;
    logic [1:0] e_done;
    logic [1:0] e_err;
    oh     = m_cli ? 2'b10 : 2'b01;
    e_gnt  = m_busy ? oh : 2'b00;
    e_done = (m_busy && t_cpl == edge_n) ? oh : 2'b00;
    e_err  = (m_busy && t_cpl == edge_n && m_err) ? oh : 2'b00;
    check("cli_gnt",      64'(bus.cli_gnt),     64'(e_gnt));
    check("cli_done",     64'(bus.cli_done),    64'(e_done));
    check("cli_err",      64'(bus.cli_err),     64'(e_err));
    check("cli_rdata",    64'(bus.cli_rdata),   64'(m_rdata));
    check("ctl_go",       64'(bus.ctl_go),      64'(m_busy && edge_n == t_grant));
    check("ctl_rdwr",     64'(bus.ctl_rdwr),    64'(m_wr));
    check("ctl_address",  64'(bus.ctl_address), 64'(m_addr));
    check("ctl_wdata",    64'(bus.ctl_wdata),   64'(m_wdata));
    check("spurious_err", 64'(spurious_err),    64'(m_spur));
    check("gnt_onehot0",  64'($onehot0(bus.cli_gnt)), 64'(1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) m_reset();
    else m_step();
    #1;
    compare_all();
  endtask

  task automatic set_client(input bit i, input bit rq, input bit wr,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (i) begin
      bus.cli_req[1] = rq; bus.cli_rdwr[1] = wr;
      bus.cli_addr[55:28] = a; bus.cli_wdata[63:32] = d;
    end else begin
      bus.cli_req[0] = rq; bus.cli_rdwr[0] = wr;
      bus.cli_addr[27:0] = a; bus.cli_wdata[31:0] = d;
    end
  endtask

  // mode 0: silent, 1: answer every WAIT cycle, 2: random answers and noise
  task automatic drive_resp(input int mode);
    bit wait_next;
    wait_next = m_busy && (t_cpl < 0) && (edge_n >= t_grant + 1);
    bus.ctl_read_data = $urandom;
    bus.ctl_read_valid = 1'b0;
    bus.ctl_write_done = 1'b0;
    if (mode == 1) begin
      bus.ctl_read_valid = wait_next;
      bus.ctl_write_done = wait_next;
    end else if (mode == 2) begin
      if (wait_next) begin
        bus.ctl_read_valid = ($urandom_range(0, 3) == 0);
        bus.ctl_write_done = ($urandom_range(0, 3) == 0);
      end else begin
        bus.ctl_read_valid = ($urandom_range(0, 63) == 0);
      end
    end
  endtask

  task automatic drive_clients_random();
    bit bi;
    bit done_i;
    for (int i = 0; i < 2; i++) begin
      bi = i[0];
      done_i = m_busy && (t_cpl == edge_n) && (m_cli == bi);
      if (bus.cli_req[bi] && !done_i) continue;
      if (bus.cli_req[bi] && $urandom_range(0, 1) == 0)
        set_client(bi, 1'b0, 1'b0, '0, '0);
      else if (bus.cli_req[bi] || $urandom_range(0, 2) == 0)
        set_client(bi, 1'b1, 1'($urandom), 28'($urandom), $urandom);
    end
  endtask

  logic [1:0] seq     [6];
  logic [1:0] exp_seq [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    int n_go;
    int cnt;
    bus.cli_req = '0; bus.cli_rdwr = '0; bus.cli_addr = '0; bus.cli_wdata = '0;
    bus.ctl_read_valid = 1'b0; bus.ctl_read_data = '0; bus.ctl_write_done = 1'b0;
    m_reset();
    repeat (3) tick();
    check("rst_gnt",  64'(bus.cli_gnt),     64'(0));
    check("rst_done", 64'(bus.cli_done),    64'(0));
    check("rst_addr", 64'(bus.ctl_address), 64'(0));
    reset = 1'b1;
    tick();

    // Single read with the fastest possible controller answer
    set_client(1'b0, 1'b1, 1'b0, 28'h8000008, 32'h0);
    tick();
    check("rd_go",   64'(bus.ctl_go),      64'(1));
    check("rd_addr", 64'(bus.ctl_address), 64'(28'h8000008));
    tick();
    bus.ctl_read_valid = 1'b1;
    bus.ctl_read_data  = 32'hAAAA0000;
    tick();
    check("rd_done",  64'(bus.cli_done),  64'(2'b01));
    check("rd_rdata", 64'(bus.cli_rdata), 64'(32'hAAAA0000));
    bus.ctl_read_valid = 1'b0;
    set_client(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();

    // Simultaneous requests from reset, then fairness over six transactions
    reset = 1'b0;
    #1;
    check("arst_gnt", 64'(bus.cli_gnt), 64'(0));
    repeat (2) tick();
    reset = 1'b1;
    set_client(1'b0, 1'b1, 1'b0, 28'h0000100, 32'h11111111);
    set_client(1'b1, 1'b1, 1'b1, 28'h0000200, 32'h22222222);
    n_go = 0;
    for (int k = 0; k < 80 && n_go < 6; k++) begin
      tick();
      if (bus.ctl_go) begin
        seq[n_go] = bus.cli_gnt;
        n_go++;
      end
      drive_resp(1);
    end
    for (int k = 0; k < 6; k++) check("fair_gnt", 64'(seq[k]), 64'(exp_seq[k]));
    set_client(1'b0, 1'b0, 1'b0, '0, '0);
    set_client(1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 20 && m_busy; k++) begin
      tick();
      drive_resp(1);
    end
    drive_resp(0);
    tick();

    // Timeout on a write from client 1
    set_client(1'b1, 1'b1, 1'b1, 28'h8000004, 32'h12345678);
    tick();
    check("to_gnt", 64'(bus.cli_gnt), 64'(2'b10));
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      cnt++;
      if (bus.cli_done != 2'b00) break;
    end
    check("to_latency", 64'(cnt),          64'(c_T + 1));
    check("to_done",    64'(bus.cli_done), 64'(2'b10));
    check("to_err",     64'(bus.cli_err),  64'(2'b10));
    set_client(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();

    // Completion lands in the very cycle the timeout would fire
    set_client(1'b0, 1'b1, 1'b1, 28'h0ABCDEF, 32'hCAFEF00D);
    tick();
    repeat (c_T) tick();
    bus.ctl_write_done = 1'b1;
    tick();
    check("tie_done",  64'(bus.cli_done),  64'(2'b01));
    check("tie_err",   64'(bus.cli_err),   64'(2'b00));
    check("tie_rdata", 64'(bus.cli_rdata), 64'(0));
    bus.ctl_write_done = 1'b0;
    set_client(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();

    // Spurious completion while idle is sticky
    bus.ctl_read_valid = 1'b1;
    tick();
    bus.ctl_read_valid = 1'b0;
    check("spur_set", 64'(spurious_err), 64'(1));
    repeat (3) tick();
    check("spur_hold", 64'(spurious_err), 64'(1));

    // Reset in the middle of WAIT
    set_client(1'b0, 1'b1, 1'b0, 28'h0000123, 32'h0);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check("wrst_done",  64'(bus.cli_done),    64'(0));
    check("wrst_gnt",   64'(bus.cli_gnt),     64'(0));
    check("wrst_addr",  64'(bus.ctl_address), 64'(0));
    check("wrst_rdata", 64'(bus.cli_rdata),   64'(0));
    check("wrst_spur",  64'(spurious_err),    64'(0));
    m_reset();
    set_client(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      drive_clients_random();
      drive_resp(2);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got no end of test, expected finish before 1000000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_ram_port_arbiter
`default_nettype wire
